// File: rtl/ram_playback_ctrl.sv
// Bus master that loads a host byte stream into an async-read RAM, then replays it as a wrapping
// sample stream. Define RAM_PLAYBACK_ONESHOT_EN to add the oneshot input and done output.
module ram_playback_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start_play,
  input  logic              stop,
`ifdef RAM_PLAYBACK_ONESHOT_EN
  input  logic              oneshot,
  output logic              done,
`endif
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  inout  wire  [DATA_W-1:0] ram_data
);

  // len can reach DEPTH == 2**ADDR_W, hence one extra bit.
  localparam int unsigned LenW = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWrite, StRead, StHold} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [LenW-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                rp_last;
`ifdef RAM_PLAYBACK_ONESHOT_EN
  logic                oneshot_q, oneshot_d;
  logic                done_q, done_d;
`endif

  // In playback ram_addr doubles as the read pointer.
  assign rp_last = ({1'b0, addr_q} == (len_q - LenW'(1)));

  always_comb begin
    state_d  = state_q;
    wp_d     = wp_q;
    len_d    = len_q;
    addr_d   = addr_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    last_d   = last_q;
    sample_d = sample_q;
    valid_d  = valid_q;
`ifdef RAM_PLAYBACK_ONESHOT_EN
    oneshot_d = oneshot_q;
    done_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          state_d = StLoad;
          wp_d    = '0;
        end else if (start_play && (len_q != '0)) begin
          state_d = StRead;
          addr_d  = '0;
`ifdef RAM_PLAYBACK_ONESHOT_EN
          oneshot_d = oneshot;
`endif
        end
      end
      StLoad: begin
        if (stop) begin
          state_d = StIdle;
          len_d   = {1'b0, wp_q};
        end else if (load_valid) begin
          state_d = StWrite;
          wdata_d = load_data;
          last_d  = load_last;
          addr_d  = wp_q;
          we_d    = 1'b1;
        end
      end
      StWrite: begin
        // The write in flight always completes, even when stopping.
        wp_d = wp_q + ADDR_W'(1);
        if (last_q || stop || (wp_q == LastAddr)) begin
          state_d = StIdle;
          len_d   = {1'b0, wp_q} + LenW'(1);
        end else begin
          state_d = StLoad;
        end
      end
      StRead: begin
        if (stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else begin
          state_d  = StHold;
          sample_d = ram_data;
          valid_d  = 1'b1;
        end
      end
      StHold: begin
        if (stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end else if (sample_ready) begin
          valid_d = 1'b0;
          state_d = StRead;
          if (rp_last) begin
            addr_d = '0;
`ifdef RAM_PLAYBACK_ONESHOT_EN
            if (oneshot_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
`endif
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      wp_q     <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      last_q   <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
`ifdef RAM_PLAYBACK_ONESHOT_EN
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wp_q     <= wp_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
`ifdef RAM_PLAYBACK_ONESHOT_EN
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
`endif
    end
  end

  assign ram_addr     = addr_q;
  assign ram_we       = we_q;
  assign ram_data     = we_q ? wdata_q : {DATA_W{1'bz}};
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != StIdle);
  assign load_ready   = (state_q == StLoad);
`ifdef RAM_PLAYBACK_ONESHOT_EN
  assign done         = done_q;
`endif

endmodule

// File: tb/tb_ram_playback_ctrl.sv
// Scoreboard bench for ram_playback_ctrl: stimulus pushes expected RAM writes and samples, a
// negedge monitor pops and compares them against what the DUT presents.
module tb_ram_playback_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_valid = 1'b0;
  logic          load_last = 1'b0;
  logic          load_ready;
  logic          start_play = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready = 1'b0;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  wire  [DW-1:0] ram_data;
`ifdef RAM_PLAYBACK_ONESHOT_EN
  logic          oneshot = 1'b0;
  logic          done;
`endif

  ram_playback_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_load   (start_load),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .start_play   (start_play),
    .stop         (stop),
`ifdef RAM_PLAYBACK_ONESHOT_EN
    .oneshot      (oneshot),
    .done         (done),
`endif
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_data     (ram_data)
  );

  always #5 clk = ~clk;

  // Async-read RAM the controller masters.
  logic [DW-1:0] ram [DEPTH];
  assign ram_data = ram_we ? {DW{1'bz}} : ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_data;

  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t           wr_q[$];
  logic [7:0]    exp_q[$];
  logic [7:0]    fixed_bytes[$];
  logic [7:0]    tbl[DEPTH];
  int            mlen = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            hs_cnt = 0;
  int            cyc = 0;
  int            last_hs = -1;
  int            done_cnt = 0;
  bit            gap_chk = 0;
  bit            playing = 0;
  bit            held = 0;
  logic [7:0]    hold_s;
  logic [AW-1:0] hold_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    wr_t w;
    logic [7:0] e;
    cyc++;
    if (ram_we) begin
      chk("ready_low_in_write", load_ready, 0);
      chk("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        chk("write_addr", ram_addr, w.a);
        chk("write_data", ram_data, w.d);
      end
    end
    if (playing) chk("no_write_in_play", ram_we, 0);
    if (sample_valid) begin
      if (held) begin
        chk("sample_stable", sample, hold_s);
        chk("addr_stable", ram_addr, hold_a);
      end
      if (sample_ready) begin
        chk("sample_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sample", sample, e);
        end
        if (gap_chk && last_hs >= 0) chk("sample_rate", cyc - last_hs, 2);
        last_hs = cyc;
        hs_cnt++;
        held = 0;
      end else begin
        held   = 1;
        hold_s = sample;
        hold_a = ram_addr;
      end
    end else begin
      held = 0;
    end
`ifdef RAM_PLAYBACK_ONESHOT_EN
    if (done) done_cnt++;
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 8 && busy; k++) @(negedge clk);
    chk(name, busy, 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_load_ready", load_ready, 0);
    wr_q.delete();
    exp_q.delete();
    mlen    = 0;
    playing = 0;
    step();
  endtask

  // stop_after: number of accepted bytes after which stop is pulsed (-1 = never).
  task automatic do_load(input int n, input bit use_last, input int stop_after);
    int acc;
    int to;
    logic [7:0] b;
    acc = 0;
    step();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    if (stop_after == 0) begin
      stop = 1'b1;
      step();
      stop = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step();
        b = (fixed_bytes.size() != 0) ? fixed_bytes.pop_front() : 8'($urandom);
        load_data  = b;
        load_last  = use_last && (i == n - 1);
        load_valid = 1'b1;
        to = 0;
        do begin
          @(negedge clk);
          to++;
        end while (!load_ready && to < 10);
        chk("load_accept", load_ready, 1);
        if (!load_ready) break;
        wr_q.push_back(wr_t'{a: 8'(i), d: b});
        tbl[i] = b;
        acc = i + 1;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (acc == stop_after) begin
          stop = 1'b1;
          step();
          stop = 1'b0;
          break;
        end
      end
    end
    mlen = acc;
    wait_idle("load_idle");
    step();
    chk("writes_drained", wr_q.size(), 0);
  endtask

  // mode 0: random ready, 1: ready always high, 2: heavy backpressure.
  task automatic do_play(input int n, input int mode);
    int to;
    for (int k = 0; k < n; k++) exp_q.push_back(tbl[k % mlen]);
    hs_cnt  = 0;
    last_hs = -1;
    gap_chk = (mode == 1);
    playing = 1;
    sample_ready = (mode == 1);
    step();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    to = 0;
    while (hs_cnt < n && to < 10 * n + 20) begin
      if (mode == 0) sample_ready = ($urandom_range(0, 3) != 0);
      if (mode == 2) sample_ready = ($urandom_range(0, 5) == 0);
      step();
      to++;
    end
    sample_ready = 1'b0;
    chk("play_count", hs_cnt, n);
    stop = 1'b1;
    step();
    stop    = 1'b0;
    playing = 0;
    gap_chk = 0;
    @(negedge clk);
    chk("stop_busy", busy, 0);
    chk("stop_valid", sample_valid, 0);
    chk("samples_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic play_empty();
    step();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    @(negedge clk);
    chk("empty_play_idle", busy, 0);
    chk("empty_play_valid", sample_valid, 0);
  endtask

  task automatic rst_mid_write();
    int to;
    step();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    load_data  = 8'h5a;
    load_valid = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!load_ready && to < 10);
    chk("mw_accept", load_ready, 1);
    wr_q.push_back(wr_t'{a: 8'd0, d: 8'h5a});
    step();
    load_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mw_we_high", ram_we, 1);
    step();
    @(negedge clk);
    chk("mw_we_released", ram_we, 0);
    chk("mw_busy", busy, 0);
    do_reset(1);
  endtask

  initial begin
    do_reset(3);
    play_empty();

    fixed_bytes = '{8'h10, 8'h20, 8'h30};
    do_load(3, 1, -1);
    chk("len3", mlen, 3);
    do_play(5, 1);
    do_play(12, 0);
    do_play(8, 2);

    // Reset during playback clears len, so a following start_play is ignored.
    for (int k = 0; k < 3; k++) exp_q.push_back(tbl[k % mlen]);
    playing = 1;
    sample_ready = 1'b1;
    step();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    repeat (4) step();
    sample_ready = 1'b0;
    do_reset(3);
    play_empty();

    fixed_bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    do_load(4, 1, 2);
    chk("len_after_stop", mlen, 2);
    do_play(5, 1);

    do_load(3, 1, 0);
    play_empty();

    for (int t = 0; t < 4; t++) begin
      do_load($urandom_range(1, 8), 1, -1);
      do_play(2 * mlen + 3, t % 3);
    end

    rst_mid_write();
    play_empty();

    do_load(DEPTH, 0, -1);
    chk("len_full", mlen, DEPTH);
    do_play(DEPTH + 4, 1);

`ifdef RAM_PLAYBACK_ONESHOT_EN
    fixed_bytes = '{8'h10, 8'h20, 8'h30};
    do_load(3, 1, -1);
    for (int k = 0; k < 3; k++) exp_q.push_back(tbl[k]);
    hs_cnt   = 0;
    done_cnt = 0;
    playing  = 1;
    sample_ready = 1'b1;
    oneshot  = 1'b1;
    step();
    start_play = 1'b1;
    step();
    start_play = 1'b0;
    oneshot    = 1'b0;
    repeat (12) step();
    sample_ready = 1'b0;
    playing = 0;
    chk("oneshot_count", hs_cnt, 3);
    chk("oneshot_done", done_cnt, 1);
    chk("oneshot_idle", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_playback_ctrl.md
Name: ram_playback_ctrl

Overview:
Bus master for the single-port, asynchronous-read RAM (`clk`, `rst`, 8-bit `address`, bidirectional 8-bit `data`).
- Loads a sample table from a host byte stream into RAM.
- Then reads the table back as a continuous, wrapping sample stream for the generator output path.
- Sole owner of the RAM address and data bus; drives the bus only on write cycles.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, sample / RAM data width
DEPTH, 256, RAM depth in words; must be <= 2**ADDR_W

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start_load  in  1  pulse: begin table load at address 0
load_data  in  DATA_W  host byte
load_valid  in  1  host byte valid
load_last  in  1  qualifies final byte of table
load_ready  out  1  controller accepts byte
start_play  in  1  pulse: begin playback at address 0
stop  in  1  abort load or playback, return to IDLE
sample  out  DATA_W  playback sample
sample_valid  out  1  sample valid
sample_ready  in  1  downstream accepts sample
busy  out  1  state != IDLE
ram_addr  out  ADDR_W  RAM address, registered
ram_we  out  1  RAM write strobe, registered
ram_data  inout  DATA_W  RAM data bus; driven only while ram_we=1, else high-Z

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state IDLE; ram_addr 0; ram_we 0; ram_data high-Z; sample 0; sample_valid 0; load_ready 0; busy 0; table length `len` 0.
- States: IDLE, LOAD, WRITE, READ, HOLD.
- IDLE:
  - start_load -> LOAD; write pointer `wp`=0.
  - else start_play with len!=0 -> READ; ram_addr=0.
  - start_play with len==0 is ignored.
  - start_load wins if both are asserted.
- LOAD:
  - load_ready=1.
  - On load_valid&load_ready: capture byte and load_last into registers -> WRITE.
- WRITE (exactly 1 cycle):
  - ram_addr=wp, ram_we=1, ram_data=captured byte; load_ready=0.
  - Next edge: ram_we=0 and wp increments.
  - If captured last, or wp==DEPTH-1: len=wp+1 -> IDLE.
  - Otherwise -> LOAD.
  - Load throughput: 1 byte per 2 cycles.
- READ (1 cycle):
  - Bus high-Z; ram_addr=rp is already stable.
  - Next edge: sample<=ram_data, sample_valid<=1 -> HOLD.
- HOLD:
  - sample and sample_valid held stable until sample_ready.
  - On handshake: sample_valid<=0; rp<=(rp==len-1)?0:rp+1; ram_addr follows -> READ.
  - Playback rate: at most 1 sample per 2 cycles.
- Wrap-around: after address len-1 playback continues at 0 indefinitely.
- stop:
  - In LOAD: -> IDLE next edge; len=number of bytes already written (0 allowed).
  - In WRITE: the write completes and counts toward len, then -> IDLE.
  - In READ/HOLD: -> IDLE, sample_valid<=0. A handshake in the same cycle as stop still counts as completed.
  - Ignored in IDLE.
- start_load/start_play outside IDLE are ignored.
- rst in any state (including mid-write): all outputs to reset values on that edge; ram_we deasserts and the bus releases the same edge; len cleared.
- ram_data is never driven and read in the same cycle; no bus contention.

Optional Feature:
Macro: RAM_PLAYBACK_ONESHOT_EN
- Defined: adds input port `oneshot` (1 bit), sampled on the start_play cycle. If it was 1, playback stops after the address len-1 handshake (-> IDLE, no wrap) and a 1-cycle `done` output pulse fires on that edge. The `done` output exists only with the macro.
- Undefined: no `oneshot`/`done` ports; playback always wraps until stop or rst.

Test Plan:
- Reset check: rst held 3 cycles during playback -> next cycle busy=0, sample_valid=0, ram_we=0, ram_data high-Z, ram_addr=0.
- Load check: start_load, stream 0x10,0x20,0x30 (last on 0x30) with load_valid=1 -> ram_we pulses at addr 0,1,2 with data 0x10/0x20/0x30; load_ready toggles 1/0; len=3; busy drops after the third write.
- Playback wrap: start_play, sample_ready=1 -> sample sequence 0x10,0x20,0x30,0x10,0x20 at one sample per 2 cycles; ram_data never driven.
- Backpressure: sample_ready=0 for 5 cycles in HOLD -> sample=0x20 and sample_valid=1 stable; ram_addr stays 1 until the handshake.
- Aborts: stop after 2 bytes of a 4-byte load -> len=2, playback yields 0x10,0x20 wrapping. start_play with len=0 -> stays IDLE.
- With RAM_PLAYBACK_ONESHOT_EN defined: start_play with oneshot=1, len=3 -> exactly 3 samples, done pulses 1 cycle on the last handshake, busy=0 afterward.
